// File: rtl/pair_sched_pkg.sv
// Shared types and helpers for the mirrored state-pair scheduler.
// The pair update function is the single source of next-state logic for both bits.
package pair_sched_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_TOGGLE = 2'b01,
    OP_LOAD   = 2'b10,
    OP_LOCK   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    EXEC,
    LOCK
  } state_e;

  function automatic logic pair_next(op_e op, logic cur, logic val);
    case (op)
      OP_TOGGLE: return !cur;
      OP_LOAD:   return val;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/pair_state_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any_valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/pair_state_sched.sv
// Round-robin scheduler owning a mirrored register pair (x, y); both bits share
// one next-state value so x == y holds by construction.
module pair_state_sched
  import pair_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int INIT_CYCLES = 3,
  parameter int LOCK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [NREQ-1:0]   load_val,
  output logic [NREQ-1:0]   gnt,
  output logic              x,
  output logic              y,
  output logic              ready,
  output logic              locked,
  output logic              err
);

  localparam int PTR_W = $clog2(NREQ);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  op_e              op_q;
  logic             val_q;

  logic [NREQ-1:0]  pick;
  logic             any_req;
  logic [PTR_W-1:0] pick_idx;
  logic             pair_nxt;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .any_valid (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = PTR_W'(i);
  end

  assign pair_nxt = pair_next(op_q, x, val_q);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT;
      cnt    <= '0;
      rr_ptr <= '0;
      gidx   <= '0;
      op_q   <= OP_NOP;
      val_q  <= 1'b0;
      gnt    <= '0;
      x      <= 1'b0;
      y      <= 1'b0;
      ready  <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= err | (x != y);
      case (state)
        INIT: begin
          if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            gidx  <= pick_idx;
            op_q  <= op_e'(op[{pick_idx, 1'b0} +: 2]);
            val_q <= load_val[pick_idx];
            ready <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          gnt    <= '0;
          x      <= pair_nxt;
          y      <= pair_nxt;
          rr_ptr <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
          if (op_q == OP_LOCK) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        LOCK: begin
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state  <= IDLE;
            cnt    <= '0;
            locked <= 1'b0;
            ready  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_state_sched.sv
// Directed bench for pair_state_sched followed by a randomised soak against a
// small behavioural model of the pair and a fairness bound.
module tb_pair_state_sched;
  import pair_sched_pkg::*;

  localparam int NREQ        = 4;
  localparam int INIT_CYCLES = 3;
  localparam int LOCK_CYCLES = 4;
  localparam int BOUND       = NREQ * (2 + LOCK_CYCLES) + INIT_CYCLES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [NREQ-1:0]   load_val;
  logic [NREQ-1:0]   gnt;
  logic              x, y, ready, locked, err;

  op_e rop [NREQ];
  int  checks = 0;
  int  errors = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_op
    assign op[2*g+1:2*g] = rop[g];
  end

  always #5 clk = ~clk;

  pair_state_sched #(
    .NREQ(NREQ), .INIT_CYCLES(INIT_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .load_val(load_val),
    .gnt(gnt), .x(x), .y(y), .ready(ready), .locked(locked), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic      x_m;
  bit        apply;
  op_e       ex_op;
  logic      ex_val;
  int        waitc [NREQ];
  int        max_wait;

  initial begin
    req = '0; load_val = '0;
    for (int i = 0; i < NREQ; i++) rop[i] = OP_NOP;

    // Reset then idle
    step(); step();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    step(); check("init_ready_1", 32'(ready), 0);
    step(); check("init_ready_2", 32'(ready), 0);
    step(); check("init_ready_3", 32'(ready), 1);
    check("init_x", 32'(x), 0);
    check("init_err", 32'(err), 0);

    // Single toggle from requester 2
    req = 4'b0100; rop[2] = OP_TOGGLE;
    step();
    check("tog_gnt", 32'(gnt), 'h4);
    check("tog_ready_low", 32'(ready), 0);
    check("tog_x_before", 32'(x), 0);
    req = '0;
    step();
    check("tog_x", 32'(x), 1);
    check("tog_y", 32'(y), 1);
    check("tog_gnt_clear", 32'(gnt), 0);
    check("tog_ready", 32'(ready), 1);

    // Load with contention from a fresh reset (rr_ptr = 0)
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    check("rst2_ready", 32'(ready), 1);
    check("rst2_x", 32'(x), 0);
    req = 4'b1011; load_val = 4'b1010;
    for (int i = 0; i < NREQ; i++) rop[i] = OP_LOAD;
    step(); check("ld_gnt0", 32'(gnt), 'h1); req[0] = 1'b0;
    step(); check("ld_gap0", 32'(gnt), 0); check("ld_x0", 32'(x), 0);
    step(); check("ld_gnt1", 32'(gnt), 'h2); req[1] = 1'b0;
    step(); check("ld_gap1", 32'(gnt), 0); check("ld_x1", 32'(x), 1);
    step(); check("ld_gnt3", 32'(gnt), 'h8); req[3] = 1'b0;
    step(); check("ld_x3", 32'(x), 1); check("ld_y3", 32'(y), 1);
    check("ld_ready", 32'(ready), 1);

    // Lock by requester 1 while requester 3 waits with a toggle
    rop[1] = OP_LOCK; rop[3] = OP_TOGGLE; req = 4'b1010;
    step(); check("lk_gnt1", 32'(gnt), 'h2); req = 4'b1000;
    for (int c = 0; c < LOCK_CYCLES; c++) begin
      step();
      check("lk_locked", 32'(locked), 1);
      check("lk_gnt_zero", 32'(gnt), 0);
      check("lk_ready_low", 32'(ready), 0);
      check("lk_x_hold", 32'(x), 1);
    end
    step();
    check("lk_exit_locked", 32'(locked), 0);
    check("lk_exit_ready", 32'(ready), 1);
    check("lk_exit_gnt", 32'(gnt), 0);
    step(); check("lk_gnt3", 32'(gnt), 'h8); req = '0;
    step(); check("lk_tog_x", 32'(x), 0);

    // Toggle to x=1, then lock and reset in the second lock cycle
    rop[0] = OP_TOGGLE; rop[1] = OP_LOCK; req = 4'b0011;
    step(); check("ml_gnt0", 32'(gnt), 'h1); req = 4'b0010;
    step(); check("ml_x1", 32'(x), 1);
    step(); check("ml_gnt1", 32'(gnt), 'h2); req = '0;
    step(); check("ml_lock_c1", 32'(locked), 1);
    step(); check("ml_lock_c2", 32'(locked), 1);
    rst = 1'b1;
    #1;
    check("ml_rst_locked", 32'(locked), 0);
    check("ml_rst_gnt", 32'(gnt), 0);
    check("ml_rst_x", 32'(x), 0);
    check("ml_rst_y", 32'(y), 0);
    check("ml_rst_ready", 32'(ready), 0);
    step(); rst = 1'b0;
    step(); check("ml_init_1", 32'(ready), 0);
    step(); check("ml_init_2", 32'(ready), 0);
    step(); check("ml_init_3", 32'(ready), 1);

    // Random soak against a behavioural model of the pair
    x_m = 1'b0; apply = 1'b0; ex_op = OP_NOP; ex_val = 1'b0; max_wait = 0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      if (apply) begin
        case (ex_op)
          OP_TOGGLE: x_m = !x_m;
          OP_LOAD:   x_m = ex_val;
          default:   x_m = x_m;
        endcase
        apply = 1'b0;
      end
      check("rnd_x", 32'(x), 32'(x_m));
      check("rnd_y", 32'(y), 32'(x_m));
      check("rnd_err", 32'(err), 0);
      check("rnd_ready_locked", 32'(ready & locked), 0);
      if (gnt != '0) begin
        check("rnd_onehot", 32'($onehot(gnt)), 1);
        check("rnd_gnt_req", 32'(|(gnt & req)), 1);
        check("rnd_gnt_exec", 32'(ready | locked), 0);
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            ex_op  = rop[i];
            ex_val = load_val[i];
            apply  = 1'b1;
            req[i] = 1'b0;
            waitc[i] = 0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end else if ($urandom_range(0, 3) == 0) begin
          req[i]      = 1'b1;
          rop[i]      = op_e'($urandom_range(0, 3));
          load_val[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    check("rnd_fair_bound", 32'(max_wait <= BOUND), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
